// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read responder.
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int BYTES_PER_WORD   = 4;
    localparam int WORD_W           = 32;
    localparam int DEF_FLASH_ADDR_W = 23;
    localparam int DEF_ACC_CYCLES   = 4;

endpackage

// File: rtl/flash_byte_assembler.sv
// Byte-index counter that inserts captured flash bytes into a 32-bit word, little-endian.
module flash_byte_assembler
    import flash_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              capture,
    input  logic [7:0]        dq,
    output logic [1:0]        byte_idx,
    output logic [WORD_W-1:0] word_next,
    output logic              done
);

    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;

    // word_next is the word as it will look once the current byte lands, so the
    // final byte can be forwarded on the same edge it is captured.
    always_comb begin
        word_next = word_q;
        word_next[{idx_q, 3'b000} +: 8] = dq;
        done   = capture && (idx_q == 2'(BYTES_PER_WORD - 1));
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = 2'd0;
            word_d = '0;
        end else if (capture) begin
            idx_d  = idx_q + 2'd1;
            word_d = word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign byte_idx = idx_q;

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM word-read responder turning each read into four byte reads on an async flash.
// Optional one-entry last-word cache enabled by defining FLASH_RESP_CACHE_EN.
module flash_read_responder
    import flash_pkg::*;
#(
    parameter int FLASH_ADDR_W = DEF_FLASH_ADDR_W,
    parameter int ACC_CYCLES   = DEF_ACC_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    // Handshake: a read is accepted on a rising edge where s_read is high and
    // s_waitrequest is low; the initiator holds s_read/s_address while stalled,
    // and the response comes later as a single-cycle s_readdatavalid pulse.
    input  logic                    s_read,
    input  logic [FLASH_ADDR_W-3:0] s_address,
    output logic                    s_waitrequest,
    output logic [WORD_W-1:0]       s_readdata,
    output logic                    s_readdatavalid,
    output logic [FLASH_ADDR_W-1:0] flash_addr,
    output logic                    flash_ce_n,
    output logic                    flash_oe_n,
    input  logic [7:0]              flash_dq,
    output logic [1:0]              dbg_state
);

    localparam int         WADDR_W  = FLASH_ADDR_W - 2;
    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [WADDR_W-1:0]      word_addr_q, word_addr_d;
    logic [3:0]              acc_cnt_q, acc_cnt_d;
    logic [FLASH_ADDR_W-1:0] flash_addr_q, flash_addr_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    rvalid_q, rvalid_d;
    logic [WORD_W-1:0]       rdata_q, rdata_d;

    logic                    asm_clear;
    logic                    asm_capture;
    logic [1:0]              asm_byte_idx;
    logic [WORD_W-1:0]       asm_word_next;
    logic                    asm_done;

    logic                    cache_hit;
    logic [WORD_W-1:0]       cache_data;

`ifdef FLASH_RESP_CACHE_EN
    logic                    cache_valid_q;
    logic [WADDR_W-1:0]      cache_addr_q;
    logic [WORD_W-1:0]       cache_data_q;
    logic                    fill_cache;

    assign cache_hit  = cache_valid_q && (cache_addr_q == s_address);
    assign cache_data = cache_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
        end else if (fill_cache) begin
            cache_valid_q <= 1'b1;
            cache_addr_q  <= word_addr_q;
            cache_data_q  <= asm_word_next;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    flash_byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .capture   (asm_capture),
        .dq        (flash_dq),
        .byte_idx  (asm_byte_idx),
        .word_next (asm_word_next),
        .done      (asm_done)
    );

    always_comb begin
        state_d      = state_q;
        word_addr_d  = word_addr_q;
        acc_cnt_d    = acc_cnt_q;
        flash_addr_d = flash_addr_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        asm_clear    = 1'b0;
        asm_capture  = 1'b0;
`ifdef FLASH_RESP_CACHE_EN
        fill_cache   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s_read) begin
                    word_addr_d = s_address;
                    if (cache_hit) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = cache_data;
                    end else begin
                        state_d      = ACCESS;
                        acc_cnt_d    = 4'd0;
                        flash_addr_d = {s_address, 2'b00};
                        ce_n_d       = 1'b0;
                        oe_n_d       = 1'b0;
                        asm_clear    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Each byte address is held for ACC_CYCLES cycles; the byte is
                // taken on the edge closing the last one, with no OE gap.
                if (acc_cnt_q == ACC_LAST) begin
                    asm_capture = 1'b1;
                    acc_cnt_d   = 4'd0;
                    if (asm_done) begin
                        state_d  = RESP;
                        ce_n_d   = 1'b1;
                        oe_n_d   = 1'b1;
                        rvalid_d = 1'b1;
                        rdata_d  = asm_word_next;
`ifdef FLASH_RESP_CACHE_EN
                        fill_cache = 1'b1;
`endif
                    end else begin
                        flash_addr_d = {word_addr_q, 2'(asm_byte_idx + 2'd1)};
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            word_addr_q  <= '0;
            acc_cnt_q    <= 4'd0;
            flash_addr_q <= '0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_addr_q  <= word_addr_d;
            acc_cnt_q    <= acc_cnt_d;
            flash_addr_q <= flash_addr_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign s_waitrequest   = (state_q != IDLE);
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvalid_q;
    assign flash_addr      = flash_addr_q;
    assign flash_ce_n      = ce_n_q;
    assign flash_oe_n      = oe_n_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_flash_read_responder.sv
// Bench for flash_read_responder: two instances (ACC_CYCLES 4 and 1), a per-cycle
// behavioural model check, and directed reads with literal expectations.
module tb_flash_read_responder;
    import flash_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rd0 = 1'b0, rd1 = 1'b0;
    logic [20:0] ad0 = '0, ad1 = '0;
    logic        wr0, wr1, rv0, rv1, ce0, ce1, oe0, oe1;
    logic [31:0] rdata0, rdata1;
    logic [22:0] fa0, fa1;
    logic [7:0]  dq0, dq1;
    logic [1:0]  st0, st1;

    // Flash model: every byte location holds the low 8 bits of its own address.
    assign dq0 = fa0[7:0];
    assign dq1 = fa1[7:0];

    flash_read_responder #(.FLASH_ADDR_W(23), .ACC_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .s_read(rd0), .s_address(ad0),
        .s_waitrequest(wr0), .s_readdata(rdata0), .s_readdatavalid(rv0),
        .flash_addr(fa0), .flash_ce_n(ce0), .flash_oe_n(oe0),
        .flash_dq(dq0), .dbg_state(st0)
    );

    flash_read_responder #(.FLASH_ADDR_W(23), .ACC_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .s_read(rd1), .s_address(ad1),
        .s_waitrequest(wr1), .s_readdata(rdata1), .s_readdatavalid(rv1),
        .flash_addr(fa1), .flash_ce_n(ce1), .flash_oe_n(oe1),
        .flash_dq(dq1), .dbg_state(st1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_active[2];
    int          m_acc[2];
    logic [20:0] m_word[2];
    bit          m_hit[2];
    logic [31:0] m_rd[2];
    bit          c_valid[2];
    logic [20:0] c_addr[2];
    logic [31:0] c_data[2];

    function automatic logic [31:0] word_data(input logic [20:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int ba;
            ba = int'(w) * 4 + k;
            r = r | (32'(ba & 255) << (8 * k));
        end
        return r;
    endfunction

    task automatic model_step(input int k, input int a, input logic wr, input logic rv,
                              input logic [31:0] rd, input logic [22:0] fa, input logic ce,
                              input logic oe, input logic rq, input logic [20:0] ad,
                              input logic [1:0] st);
        int    d;
        bit    acc_ph;
        bit    resp_ph;
        string s;
        s = (k == 0) ? "a4" : "a1";
        acc_ph  = 1'b0;
        resp_ph = 1'b0;
        d = 0;
        if (m_active[k]) begin
            d = cyc - m_acc[k];
            if (m_hit[k]) begin
                if (d == 0) begin
                    resp_ph = 1'b1;
                    m_rd[k] = c_data[k];
                end else m_active[k] = 1'b0;
            end else if (d < 4 * a) begin
                acc_ph = 1'b1;
            end else if (d == 4 * a) begin
                resp_ph    = 1'b1;
                m_rd[k]    = word_data(m_word[k]);
                c_valid[k] = 1'b1;
                c_addr[k]  = m_word[k];
                c_data[k]  = m_rd[k];
            end else m_active[k] = 1'b0;
        end
        chk({"model_waitreq_", s}, 32'(wr), 32'(acc_ph | resp_ph));
        chk({"model_rvalid_", s}, 32'(rv), 32'(resp_ph));
        chk({"model_rdata_", s}, rd, m_rd[k]);
        chk({"model_ce_n_", s}, 32'(ce), 32'(!acc_ph));
        chk({"model_oe_n_", s}, 32'(oe), 32'(!acc_ph));
        chk({"model_state_", s}, 32'(st),
            acc_ph ? 32'(ACCESS) : (resp_ph ? 32'(RESP) : 32'(IDLE)));
        if (acc_ph) chk({"model_flash_addr_", s}, 32'(fa), 32'({m_word[k], 2'(d / a)}));
        // Decide what the next edge does with the inputs now presented.
        if (reset) begin
            m_active[k] = 1'b0;
            m_rd[k]     = '0;
            c_valid[k]  = 1'b0;
        end else if (!m_active[k] && rq) begin
            m_active[k] = 1'b1;
            m_acc[k]    = cyc + 1;
            m_word[k]   = ad;
`ifdef FLASH_RESP_CACHE_EN
            m_hit[k]    = c_valid[k] && (c_addr[k] == ad);
`else
            m_hit[k]    = 1'b0;
`endif
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, wr0, rv0, rdata0, fa0, ce0, oe0, rd0, ad0, st0);
        model_step(1, 1, wr1, rv1, rdata1, fa1, ce1, oe1, rd1, ad1, st1);
    end

    // ---------------- drivers ----------------
    function automatic logic get_wr(input int k);
        return (k == 0) ? wr0 : wr1;
    endfunction
    function automatic logic get_rv(input int k);
        return (k == 0) ? rv0 : rv1;
    endfunction
    function automatic logic [31:0] get_rd(input int k);
        return (k == 0) ? rdata0 : rdata1;
    endfunction

    task automatic drive(input int k, input logic r, input logic [20:0] a);
        if (k == 0) begin
            rd0 = r;
            ad0 = a;
        end else begin
            rd1 = r;
            ad1 = a;
        end
    endtask

    task automatic wait_accept(input int k, output int acc_c);
        bit ok;
        ok = 1'b0;
        acc_c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!get_wr(k)) begin
                ok = 1'b1;
                acc_c = cyc + 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int k, output logic [31:0] data, output int lat);
        bit ok;
        ok = 1'b0;
        lat = -1;
        data = 'x;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (get_rv(k)) begin
                ok = 1'b1;
                lat = n;
                data = get_rd(k);
                break;
            end
        end
        if (!ok) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input int k, input logic [20:0] a, output logic [31:0] data,
                           output int lat);
        int acc_c;
        @(posedge clk); #1;
        drive(k, 1'b1, a);
        wait_accept(k, acc_c);
        @(posedge clk); #1;
        drive(k, 1'b0, a);
        wait_valid(k, data, lat);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d1, d2;
        int          lat, lat2, acc1, acc2, seen;

        // Reset with s_read already high: the request must be ignored.
        drive(0, 1'b1, 21'h9);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, 21'h0);
        @(negedge clk);
        chk("reset_waitreq", 32'(wr0), 32'd0);
        chk("reset_rvalid", 32'(rv0), 32'd0);
        chk("reset_rdata", rdata0, 32'h0);
        chk("reset_flash_addr", 32'(fa0), 32'h0);
        chk("reset_ce_oe", {30'd0, ce0, oe0}, 32'h3);
        chk("reset_state", 32'(st0), 32'(IDLE));
        chk("reset_state_a1", 32'(st1), 32'(IDLE));

        // Single read, word 0x10.
        do_read(0, 21'h10, d1, lat);
        chk("single_data", d1, 32'h43424140);
        chk("single_latency", 32'(lat), 32'd17);

        // Back-to-back with s_read held high.
        @(posedge clk); #1;
        drive(0, 1'b1, 21'h1);
        wait_accept(0, acc1);
        @(posedge clk); #1;
        drive(0, 1'b1, 21'h2);
        wait_valid(0, d1, lat);
        wait_accept(0, acc2);
        @(posedge clk); #1;
        drive(0, 1'b0, 21'h2);
        wait_valid(0, d2, lat2);
        chk("b2b_data0", d1, 32'h07060504);
        chk("b2b_data1", d2, 32'h0B0A0908);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd18);
        chk("b2b_latency1", 32'(lat2), 32'd17);

        // Reset six cycles into ACCESS.
        @(posedge clk); #1;
        drive(0, 1'b1, 21'h5);
        wait_accept(0, acc1);
        @(posedge clk); #1;
        drive(0, 1'b0, 21'h5);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ce_oe", {30'd0, ce0, oe0}, 32'h3);
        chk("abort_state", 32'(st0), 32'(IDLE));
        chk("abort_rdata", rdata0, 32'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rv0) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        do_read(0, 21'h5, d1, lat);
        chk("after_abort_data", d1, 32'h17161514);
        chk("after_abort_latency", 32'(lat), 32'd17);

        // Highest word address: bytes 0x7FFFFC..0x7FFFFF, no carry out.
        do_read(0, 21'h1FFFFF, d1, lat);
        chk("wrap_data", d1, 32'hFFFEFDFC);

        // ACC_CYCLES = 1 instance.
        do_read(1, 21'h3, d1, lat);
        chk("acc1_data", d1, 32'h0F0E0D0C);
        chk("acc1_latency", 32'(lat), 32'd5);

`ifdef FLASH_RESP_CACHE_EN
        do_read(0, 21'h20, d1, lat);
        chk("cache_miss_latency", 32'(lat), 32'd17);
        chk("cache_miss_data", d1, 32'h83828180);
        do_read(0, 21'h20, d2, lat2);
        chk("cache_hit_latency", 32'(lat2), 32'd1);
        chk("cache_hit_data", d2, 32'h83828180);
        pulse_reset();
        do_read(0, 21'h20, d1, lat);
        chk("cache_after_reset_latency", 32'(lat), 32'd17);
`else
        do_read(0, 21'h20, d1, lat);
        do_read(0, 21'h20, d2, lat2);
        chk("repeat_data", d2, 32'h83828180);
        chk("repeat_latency", 32'(lat2), 32'd17);
        pulse_reset();
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
